// File: rtl/light_sequence_monitor.sv
// Purpose : passive checker on the three intersection light codes; flags illegal
//           encodings, conflicting greens, bad sequencing, short yellow/all-red
//           and over-long red, with a sticky first-fault code and a violation count.
// Latency : 1 cycle from sample to viol/fault/fault_code/viol_count.
// Backpressure: none; samples every cycle and never stalls the controller.
// Ports   : Clock, Reset (sync, active-high); L1/L2/L3 2-bit light codes
//           (01 GREEN, 10 YELLOW, 11 RED, 00 illegal); viol one-cycle pulse per
//           violating sample; fault sticky flag; fault_code lowest code of the
//           first violating sample; viol_count saturating count of violating samples.
module light_sequence_monitor #(
    parameter int YELLOW_MIN = 3,
    parameter int ALLRED_MIN = 1,
    parameter int MAX_RED    = 200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    output logic       viol,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] viol_count
);

    localparam logic [1:0] C_ILL = 2'b00;
    localparam logic [1:0] C_G   = 2'b01;
    localparam logic [1:0] C_Y   = 2'b10;
    localparam logic [1:0] C_R   = 2'b11;

    localparam logic [7:0] YEL_MIN  = 8'(YELLOW_MIN);
    localparam logic [7:0] AR_MIN   = 8'(ALLRED_MIN);
    localparam logic [7:0] RED_MAX  = 8'(MAX_RED);
    localparam logic [7:0] SAT      = 8'hFF;

    // Index 0 is L1 (NB 4th Ave), 1 is L2 (EB Harrison), 2 is L3 (WB Harrison).
    logic [2:0][1:0] cur;
    logic [2:0][1:0] prev_q;
    logic [2:0][7:0] run_q;
    logic [2:0][7:0] run_d;
    logic            prev_valid_q;
    logic [7:0]      allred_q;
    logic [7:0]      allred_d;
    logic [7:1]      hit;
    logic            any_hit;
    logic [2:0]      first_code;

    assign cur = {L3, L2, L1};

    function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
        return ((p == C_G) && (c == C_Y)) ||
               ((p == C_Y) && (c == C_R)) ||
               ((p == C_R) && (c == C_G));
    endfunction

    always_comb begin
        hit        = '0;
        run_d      = '0;
        allred_d   = '0;
        first_code = 3'd0;

        for (int i = 0; i < 3; i++) begin
            // Run counters restart at 1 on a colour change or on the first
            // sample after reset, otherwise count up and stick at 255.
            if (prev_valid_q && (cur[i] == prev_q[i]))
                run_d[i] = (run_q[i] == SAT) ? SAT : run_q[i] + 8'd1;
            else
                run_d[i] = 8'd1;

            if (cur[i] == C_ILL)
                hit[1] = 1'b1;

            if (prev_valid_q) begin
                if ((cur[i] != prev_q[i]) && !legal_step(prev_q[i], cur[i]))
                    hit[3] = 1'b1;
                // run_q still holds the length of the yellow run just ending.
                if ((prev_q[i] == C_Y) && (cur[i] == C_R) && (run_q[i] < YEL_MIN))
                    hit[4] = 1'b1;
                // allred_q reflects the previous sample, i.e. the clearance
                // interval that preceded this green.
                if ((prev_q[i] == C_R) && (cur[i] == C_G) && (allred_q < AR_MIN))
                    hit[5] = 1'b1;
                // Fires only on the step from MAX_RED to MAX_RED+1; a saturated
                // counter never equals MAX_RED again, so once per red run.
                if ((prev_q[i] == C_R) && (cur[i] == C_R) && (run_q[i] == RED_MAX))
                    hit[7] = 1'b1;
            end
        end

        hit[2] = (cur[0] != C_R) && ((cur[1] != C_R) || (cur[2] != C_R));
        hit[6] = (cur[1] != cur[2]);

        if ((cur[0] == C_R) && (cur[1] == C_R) && (cur[2] == C_R))
            allred_d = (allred_q == SAT) ? SAT : allred_q + 8'd1;

        // Lowest-numbered code wins when several coincide.
        for (int c = 7; c >= 1; c--) begin
            if (hit[c])
                first_code = 3'(c);
        end
    end

    assign any_hit = |hit;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            run_q        <= '0;
            allred_q     <= '0;
            viol         <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= 3'd0;
            viol_count   <= 8'd0;
        end else begin
            prev_q       <= cur;
            prev_valid_q <= 1'b1;
            run_q        <= run_d;
            allred_q     <= allred_d;
            viol         <= any_hit;
            if (any_hit && !fault) begin
                fault      <= 1'b1;
                fault_code <= first_code;
            end
            if (any_hit && (viol_count != SAT))
                viol_count <= viol_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Directed bench for light_sequence_monitor with default parameters
// (YELLOW_MIN=3, ALLRED_MIN=1, MAX_RED=200). Each sample is applied, the
// clock edge taken, and outputs observed 1 time unit later.
module tb_light_sequence_monitor;

    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] R = 2'b11;
    localparam logic [1:0] X = 2'b00;

    logic       Clock;
    logic       Reset;
    logic [1:0] L1, L2, L3;
    logic       viol;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] viol_count;

    int vectors;
    int miscompares;

    light_sequence_monitor dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .L1         (L1),
        .L2         (L2),
        .L3         (L3),
        .viol       (viol),
        .fault      (fault),
        .fault_code (fault_code),
        .viol_count (viol_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic apply(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        L1 = a;
        L2 = b;
        L3 = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_n(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                           input int n);
        for (int k = 0; k < n; k++)
            apply(a, b, c);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        L1 = R; L2 = R; L3 = R;
        do_reset();
        vectors++;
        if (viol !== 1'b0) begin
            $display("FAIL reset_viol: got %0b want 0", viol); miscompares++;
        end
        vectors++;
        if (fault !== 1'b0) begin
            $display("FAIL reset_fault: got %0b want 0", fault); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd0) begin
            $display("FAIL reset_code: got %0d want 0", fault_code); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd0) begin
            $display("FAIL reset_count: got %0d want 0", viol_count); miscompares++;
        end
    endtask

    task automatic test_legal_cycle();
        logic [1:0] sa [7];
        logic [1:0] sb [7];
        int         reps [7];
        int         bad;
        sa = '{R, G, Y, R, R, R, R};
        sb = '{R, R, R, R, G, Y, R};
        reps = '{1, 45, 5, 1, 15, 5, 1};
        bad = 0;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            for (int s = 0; s < 7; s++) begin
                for (int k = 0; k < reps[s]; k++) begin
                    apply(sa[s], sb[s], sb[s]);
                    vectors++;
                    if (viol !== 1'b0) begin
                        if (bad < 5)
                            $display("FAIL legal_viol: step %0d got %0b want 0", s, viol);
                        bad++;
                        miscompares++;
                    end
                end
            end
        end
        vectors++;
        if (fault !== 1'b0) begin
            $display("FAIL legal_fault: got %0b want 0", fault); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd0) begin
            $display("FAIL legal_count: got %0d want 0", viol_count); miscompares++;
        end
    endtask

    task automatic test_conflict();
        do_reset();
        apply(R, R, R);
        apply_n(G, R, R, 3);
        apply(G, G, G);
        vectors++;
        if (viol !== 1'b1) begin
            $display("FAIL conflict_viol: got %0b want 1", viol); miscompares++;
        end
        vectors++;
        if (fault !== 1'b1) begin
            $display("FAIL conflict_fault: got %0b want 1", fault); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd2) begin
            $display("FAIL conflict_code: got %0d want 2", fault_code); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd1) begin
            $display("FAIL conflict_count: got %0d want 1", viol_count); miscompares++;
        end
        // Return to GRR: L2/L3 step G->R, an illegal transition.
        apply(G, R, R);
        vectors++;
        if (viol_count !== 8'd2) begin
            $display("FAIL conflict_count2: got %0d want 2", viol_count); miscompares++;
        end
        apply(X, R, R);
        vectors++;
        if (viol_count !== 8'd3) begin
            $display("FAIL conflict_count3: got %0d want 3", viol_count); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd2) begin
            $display("FAIL conflict_sticky: got %0d want 2", fault_code); miscompares++;
        end
    endtask

    task automatic test_short_yellow();
        do_reset();
        apply(R, R, R);
        apply_n(G, R, R, 10);
        apply_n(Y, R, R, 2);
        vectors++;
        if (fault !== 1'b0) begin
            $display("FAIL shorty_pre: got %0b want 0", fault); miscompares++;
        end
        apply(R, R, R);
        vectors++;
        if (viol !== 1'b1) begin
            $display("FAIL shorty_viol: got %0b want 1", viol); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd4) begin
            $display("FAIL shorty_code: got %0d want 4", fault_code); miscompares++;
        end
        do_reset();
        apply(R, R, R);
        apply_n(G, R, R, 10);
        apply_n(Y, R, R, 3);
        apply(R, R, R);
        vectors++;
        if (fault !== 1'b0) begin
            $display("FAIL yellow3_fault: got %0b want 0", fault); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd0) begin
            $display("FAIL yellow3_count: got %0d want 0", viol_count); miscompares++;
        end
    endtask

    task automatic test_missing_clearance();
        do_reset();
        apply(R, R, R);
        apply_n(R, G, G, 3);
        apply_n(R, Y, Y, 5);
        apply(G, R, R);
        vectors++;
        if (viol !== 1'b1) begin
            $display("FAIL clear_viol: got %0b want 1", viol); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd5) begin
            $display("FAIL clear_code: got %0d want 5", fault_code); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd1) begin
            $display("FAIL clear_count: got %0d want 1", viol_count); miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        // L1 G->R with L2=G, L3=R: L1 is red so no conflict; codes 3, 5, 6 present.
        do_reset();
        apply(R, R, R);
        apply_n(G, R, R, 3);
        apply(R, G, R);
        vectors++;
        if (viol !== 1'b1) begin
            $display("FAIL simul_a_viol: got %0b want 1", viol); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd1) begin
            $display("FAIL simul_a_count: got %0d want 1", viol_count); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd3) begin
            $display("FAIL simul_a_code: got %0d want 3", fault_code); miscompares++;
        end
        // L1 Y->G with L2=G, L3=R: codes 2, 3, 5, 6 together in one sample.
        do_reset();
        apply(R, R, R);
        apply_n(G, R, R, 3);
        apply_n(Y, R, R, 3);
        apply(G, G, R);
        vectors++;
        if (viol !== 1'b1) begin
            $display("FAIL simul_b_viol: got %0b want 1", viol); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd1) begin
            $display("FAIL simul_b_count: got %0d want 1", viol_count); miscompares++;
        end
        vectors++;
        if (fault_code !== 3'd2) begin
            $display("FAIL simul_b_code: got %0d want 2", fault_code); miscompares++;
        end
    endtask

    task automatic test_watchdog();
        logic exp_v;
        int   bad;
        bad = 0;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            apply(R, G, G);
            exp_v = (k == 201);
            vectors++;
            if (viol !== exp_v) begin
                if (bad < 5)
                    $display("FAIL watchdog_viol: sample %0d got %0b want %0b", k, viol, exp_v);
                bad++;
                miscompares++;
            end
        end
        vectors++;
        if (fault_code !== 3'd7) begin
            $display("FAIL watchdog_code: got %0d want 7", fault_code); miscompares++;
        end
        vectors++;
        if (viol_count !== 8'd1) begin
            $display("FAIL watchdog_count: got %0d want 1", viol_count); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            apply(X, R, R);
            exp_c = (k < 255) ? 8'(k) : 8'd255;
            if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256 || k == 300) begin
                vectors++;
                if (viol_count !== exp_c) begin
                    $display("FAIL sat_count: sample %0d got %0d want %0d", k, viol_count, exp_c);
                    miscompares++;
                end
                vectors++;
                if (viol !== 1'b1) begin
                    $display("FAIL sat_viol: sample %0d got %0b want 1", k, viol);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (fault_code !== 3'd1) begin
            $display("FAIL sat_code: got %0d want 1", fault_code); miscompares++;
        end
        // Reset in the middle of a faulted run clears everything on that edge.
        do_reset();
        vectors++;
        if ({viol, fault, fault_code, viol_count} !== 13'd0) begin
            $display("FAIL midreset: got viol=%0b fault=%0b code=%0d count=%0d want all 0",
                     viol, fault, fault_code, viol_count);
            miscompares++;
        end
        // First sample after reset only loads history: R->G of L1 is not checked.
        apply(G, R, R);
        vectors++;
        if (viol !== 1'b0) begin
            $display("FAIL first_sample: got %0b want 0", viol); miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        L1 = R; L2 = R; L3 = R;
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_short_yellow();
        test_missing_clearance();
        test_simultaneous();
        test_watchdog();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
